// File: rtl/watch_pkg.sv
// Shared encodings for the watch set controller: FSM states and FND blank bits.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam int unsigned BLANK_MSEC = 0;
    localparam int unsigned BLANK_SEC  = 1;
    localparam int unsigned BLANK_MIN  = 2;
    localparam int unsigned BLANK_HOUR = 3;

    function automatic state_t next_field(input state_t s);
        case (s)
            IDLE:     next_field = SET_HOUR;
            SET_HOUR: next_field = SET_MIN;
            SET_MIN:  next_field = SET_SEC;
            default:  next_field = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/watch_set_cu.sv
// Watch time-setting controller: field FSM, up-button pulse/auto-repeat, field blink.
// Optional inactivity timeout back to IDLE when WATCH_SET_TIMEOUT_EN is defined.
module watch_set_cu
    import watch_pkg::*;
#(
    parameter int unsigned TICK_DIV         = 100_000,
    parameter int unsigned REPEAT_DELAY_MS  = 500,
    parameter int unsigned REPEAT_PERIOD_MS = 100,
    parameter int unsigned BLINK_MS         = 250,
    parameter int unsigned TIMEOUT_MS       = 10_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic [3:0] o_blank,
    output logic       o_setting
);

    localparam int unsigned HW = $clog2(REPEAT_DELAY_MS + 1);
    localparam int unsigned BW = $clog2(BLINK_MS + 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY_MS - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY_MS - REPEAT_PERIOD_MS);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_MS - 1);

    state_t        r_state, w_next;
    logic          r_mode_q, r_mode_d, r_up_q, r_up_d;
    logic          r_inc_sec, r_inc_min, r_inc_hour;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [BW-1:0] r_blink, w_blink_nxt;
    logic          r_phase, w_phase_nxt;
    logic          w_tick, w_set, w_mode_rise, w_up_rise, w_repeat, w_fire, w_chg;
    logic          w_timeout;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_set       = (r_state != IDLE);
    assign w_mode_rise = r_mode_q & ~r_mode_d;
    assign w_up_rise   = r_up_q & ~r_up_d;
    assign w_repeat    = r_up_q & w_tick & (r_hold == HOLD_LAST);

`ifdef WATCH_SET_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_MS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_MS - 1);

    logic [TW-1:0] r_to, w_to_nxt;

    assign w_timeout = w_set & w_tick & ~w_mode_rise & ~w_up_rise & (r_to == TO_LAST);

    always_comb begin
        w_to_nxt = r_to;
        if (!w_set || w_chg || w_mode_rise || w_up_rise)
            w_to_nxt = '0;
        else if (w_tick)
            w_to_nxt = r_to + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_to <= '0;
        else       r_to <= w_to_nxt;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (!i_enable)
            w_next = IDLE;
        else if (w_mode_rise)
            w_next = next_field(r_state);
        else if (w_timeout)
            w_next = IDLE;
    end

    assign w_chg  = (w_next != r_state);
    // mode, disable and timeout all take priority over an up pulse in the same cycle
    assign w_fire = w_set & i_enable & ~w_mode_rise & ~w_timeout & (w_up_rise | w_repeat);

    // After the first repeat the counter reloads so it reaches HOLD_LAST every period
    always_comb begin
        w_hold_nxt = r_hold;
        if (!w_set || !i_enable || !r_up_q || w_mode_rise || w_chg)
            w_hold_nxt = '0;
        else if (w_tick)
            w_hold_nxt = (r_hold == HOLD_LAST) ? HOLD_RELOAD : r_hold + 1'b1;
    end

    always_comb begin
        w_blink_nxt = r_blink;
        w_phase_nxt = r_phase;
        if (!w_set || w_chg || w_fire) begin
            w_blink_nxt = '0;
            w_phase_nxt = 1'b0;
        end else if (w_tick) begin
            if (r_blink == BLINK_LAST) begin
                w_blink_nxt = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_blink_nxt = r_blink + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mode_q   <= 1'b0;
            r_mode_d   <= 1'b0;
            r_up_q     <= 1'b0;
            r_up_d     <= 1'b0;
            r_inc_sec  <= 1'b0;
            r_inc_min  <= 1'b0;
            r_inc_hour <= 1'b0;
            r_hold     <= '0;
            r_blink    <= '0;
            r_phase    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mode_q   <= i_btn_mode;
            r_mode_d   <= r_mode_q;
            r_up_q     <= i_btn_up;
            r_up_d     <= r_up_q;
            r_inc_sec  <= w_fire & (r_state == SET_SEC);
            r_inc_min  <= w_fire & (r_state == SET_MIN);
            r_inc_hour <= w_fire & (r_state == SET_HOUR);
            r_hold     <= w_hold_nxt;
            r_blink    <= w_blink_nxt;
            r_phase    <= w_phase_nxt;
        end
    end

    always_comb begin
        o_blank = '0;
        case (r_state)
            SET_HOUR: o_blank[BLANK_HOUR] = r_phase;
            SET_MIN:  o_blank[BLANK_MIN]  = r_phase;
            SET_SEC:  o_blank[BLANK_SEC]  = r_phase;
            default:  o_blank = '0;
        endcase
    end

    assign o_setting  = w_set;
    assign o_inc_sec  = r_inc_sec;
    assign o_inc_min  = r_inc_min;
    assign o_inc_hour = r_inc_hour;

endmodule

// File: doc/watch_set_cu.md
# watch_set_cu

Time-setting controller for the real-time watch datapath. Sequences the operator through hour/minute/second field selection, converts a single debounced "up" button into single-cycle increment pulses with hold-to-auto-repeat, and drives a per-field blank mask so the selected field blinks on the FND. Sits between the button debouncers and the watch datapath's increment inputs, alongside the FND controller.

## Interface

Parameters:
- TICK_DIV, 100_000, clk cycles per internal 1 ms tick (100 MHz clk)
- REPEAT_DELAY_MS, 500, hold time before the first auto-repeat pulse
- REPEAT_PERIOD_MS, 100, interval between auto-repeat pulses
- BLINK_MS, 250, half-period of the field blink
- TIMEOUT_MS, 10_000, inactivity time before leaving set mode

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- i_enable  in  1  level; high when the watch display is selected
- i_btn_mode  in  1  debounced level; advances the field selection
- i_btn_up  in  1  debounced level; increments the selected field
- o_inc_sec  out  1  single-cycle increment pulse to the seconds field
- o_inc_min  out  1  single-cycle increment pulse to the minutes field
- o_inc_hour  out  1  single-cycle increment pulse to the hours field
- o_blank  out  4  FND blank mask; bit0 msec, bit1 sec, bit2 min, bit3 hour
- o_setting  out  1  high in any set state

## Operation

- FSM states: IDLE=2'b00, SET_HOUR=2'b01, SET_MIN=2'b10, SET_SEC=2'b11.
- Rising edge of i_btn_mode: IDLE→SET_HOUR→SET_MIN→SET_SEC→IDLE.
- Edge detection: each button is registered once; rise = current & ~previous.
- In a set state, a rising edge of i_btn_up gives one pulse on the output for the selected field. In IDLE, i_btn_up is ignored.
- Auto-repeat: a hold counter counts ms ticks while i_btn_up stays high.
  - One pulse when the count reaches REPEAT_DELAY_MS.
  - Then one pulse every REPEAT_PERIOD_MS ticks while held.
  - The counter clears on release, on state change and on i_enable low.
- At most one o_inc_* is high in any cycle.
- Blink: a phase counter restarts at "visible" on entering a set state and on every increment pulse.
  - The selected field's o_blank bit is 0 for BLINK_MS ticks, then 1 for BLINK_MS ticks, repeating.
  - All other bits are 0.
  - In IDLE, o_blank = 4'b0000.
- Simultaneous mode rise and up rise in the same cycle: mode wins. No increment pulse, and the hold counter clears.
- i_enable low: next state is IDLE. Increment pulses are suppressed from that same cycle. Blink and hold counters clear.
- Field wrap-around is owned by the datapath; this block only pulses.

## Timing

- Reset values: state IDLE, o_inc_* 0, o_blank 0, o_setting 0, all counters 0.
- Edge-to-pulse latency: a button rise sampled at clock edge N produces its o_inc_* pulse in the cycle after edge N+1. That is 2 cycles of latency: one input register plus a registered output.
- Each pulse is exactly one clk cycle wide.
- The ms tick is a one-cycle strobe every TICK_DIV clocks. Its divider free-runs from reset and is not resynchronised by buttons, so ms intervals carry up to 1 tick of jitter.
- State transitions take effect one cycle after the registered mode edge. o_setting and o_blank follow the state register with no extra delay.
- Reset asserted mid-hold or mid-blink: outputs drop to reset values asynchronously, and no pulse is emitted on release of reset.

## Configuration

- Macro WATCH_SET_TIMEOUT_EN.
- Defined: an inactivity counter counts ms ticks in set states. It clears on every mode or up rise and on state entry. On reaching TIMEOUT_MS the state returns to IDLE, and no increment pulse is issued.
- Undefined: the counter and its logic are absent; set mode exits only via the mode button, i_enable or reset.

## Structure

- Shared package/header watch_pkg holds:
  - the state encodings
  - the o_blank bit indices (BLANK_MSEC=0, BLANK_SEC=1, BLANK_MIN=2, BLANK_HOUR=3)
- One sub-module, ms_tick_gen (parameter TICK_DIV, output o_tick): the ms strobe, reused for other watch timing.
- Everything else (FSM, edge detect, hold/repeat, blink, timeout) is in watch_set_cu.

## Test plan

Run with TICK_DIV=2, REPEAT_DELAY_MS=5, REPEAT_PERIOD_MS=2, BLINK_MS=3, TIMEOUT_MS=20.

- Four mode rises from IDLE → states 01, 10, 11, 00 in order; o_setting goes 1,1,1,0.
- SET_MIN, up pulsed for 1 cycle → exactly one o_inc_min, 2 cycles after the rise; o_inc_sec and o_inc_hour stay 0.
- SET_HOUR, up held for 9 ms → 1 initial pulse, a repeat at 5 ms, then repeats at 7 ms and 9 ms. Total 4 o_inc_hour pulses; none after release.
- SET_SEC, idle → o_blank toggles 4'b0000/4'b0010 every 3 ms. With WATCH_SET_TIMEOUT_EN defined, the state returns to IDLE at 20 ms with o_blank 0. Without the macro, it stays in SET_SEC.
- Mode and up rising in the same cycle in SET_HOUR → state becomes SET_MIN; zero increment pulses.
- i_enable dropped while up is held in SET_MIN → IDLE the next cycle, no further pulses. Reset asserted mid-hold → all outputs 0 immediately.
